ext_pipe: RTL
=============

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the datapath word width in bits (32 or 64).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the misalignment counter.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: an upstream request is present this cycle.
REQ-006 Port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 Port in_data, input, DATA_W bits: the raw memory word.
REQ-008 Port in_offset, input, log2(DATA_W/8) bits: the byte offset within the word.
REQ-009 Port in_size, input, 2 bits: access size; 0 = byte, 1 = half, 2 = word, 3 = dword (dword is legal only when DATA_W = 64).
REQ-010 Port in_signext, input, 1 bit: 1 = sign-extend, 0 = zero-extend.
REQ-011 Port out_valid, output, 1 bit: a result is present.
REQ-012 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 Port out_data, output, DATA_W bits: the extracted and extended result.
REQ-014 Port out_misalign, output, 1 bit: the result is flagged as a misaligned access.
REQ-015 Port misalign_cnt, output, CNT_W bits: saturating count of misaligned requests.

Function
REQ-016 A transfer SHALL occur on an edge where in_valid and in_ready are both 1; likewise for out_valid and out_ready.
REQ-017 The field SHALL be in_data[offset*8 +: size_bits], where size_bits = 8 << in_size.
REQ-018 The field SHALL be extended to DATA_W bits:
  - in_signext = 1: replicate the field MSB.
  - in_signext = 0: fill with zeros.
  - size_bits = DATA_W: pass through unchanged.
REQ-019 Misaligned SHALL mean (offset mod (size_bits/8)) != 0, or in_size illegal for DATA_W; a misaligned result SHALL have out_data = 0 and out_misalign = 1.
REQ-020 Latency SHALL be exactly 1 cycle: a request accepted at edge N appears on out_valid/out_data after edge N when the output stage is empty.
REQ-021 The block SHALL be a 2-entry skid buffer, with states:
  - EMPTY: out_valid = 0, in_ready = 1.
  - ONE: out_valid = 1, in_ready = 1.
  - FULL: out_valid = 1, in_ready = 0.
REQ-022 State transitions SHALL be:
  - EMPTY -> ONE on input transfer.
  - ONE -> FULL on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - ONE -> ONE on both transfers, or on neither.
  - FULL -> ONE on output transfer; the skid entry moves into the output register.
REQ-023 in_ready SHALL be a register output with no combinational path from out_ready.
REQ-024 Sustained in_valid = out_ready = 1 SHALL give one result per cycle with no bubbles.
REQ-025 While out_valid = 1 and out_ready = 0, out_data and out_misalign SHALL hold stable.
REQ-026 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-027 misalign_cnt SHALL increment by 1 on each accepted misaligned request and saturate at 2^CNT_W - 1 without wrapping.
REQ-028 Inputs sampled when in_ready = 0 SHALL be ignored.

Reset
REQ-029 On a clk edge with reset_n = 0, the block SHALL enter EMPTY:
  - out_valid = 0, in_ready = 1.
  - out_data = 0, out_misalign = 0, misalign_cnt = 0.
REQ-030 Reset asserted mid-operation SHALL discard all buffered results.
REQ-031 Reset SHALL take priority over any simultaneous transfer.
REQ-032 In the first cycle after reset_n returns to 1, the block SHALL accept a request.

Structure
REQ-033 Package ext_pkg SHALL hold the size encoding enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD) and the buffer state enum (EMPTY, ONE, FULL).
REQ-034 The extraction/extension logic SHALL be a purely combinational sub-module ext_field (parameter DATA_W), instantiated once ahead of the buffer so that only extended results are stored.

Verification
REQ-035 With DATA_W = 32, the bench SHALL cover these cases (each result after 1 cycle):
  - in_data = 0x1234_80FF, offset = 1, byte, signext = 1 -> out_data = 0xFFFF_FF80.
  - Same, signext = 0 -> out_data = 0x0000_0080.
  - Half, offset = 2, signext = 1 -> out_data = 0x0000_1234.
REQ-036 Half access at offset 1 -> out_misalign = 1, out_data = 0, misalign_cnt increments 0 -> 1; with CNT_W = 2, five misaligned requests -> misalign_cnt = 3.
REQ-037 Hold out_ready = 0 and send 3 requests -> the first two are accepted, in_ready = 0 after the second, out_data stable; raise out_ready -> both results delivered in order, then the third request is accepted.
REQ-038 100 back-to-back requests with out_ready = 1 -> 100 results in 101 cycles, in order.
REQ-039 reset_n = 0 while in FULL -> next cycle out_valid = 0, in_ready = 1, misalign_cnt = 0, and no stale result appears afterward.
REQ-040 With DATA_W = 64, dword access at offset 0 -> passthrough; dword at offset 4 -> misaligned; in_size = 3 with DATA_W = 32 -> misaligned.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the extract/extend pipeline: access size codes and
// output skid-buffer occupancy states.
package ext_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_e;

endpackage

// File: rtl/ext_field.sv
// Combinational field extraction: selects a byte/half/word/dword at a byte
// offset, sign- or zero-extends it, and zeroes misaligned or illegal accesses.
module ext_field
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int OFF_W = $clog2(DATA_W/8)
) (
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_offset,
   input  logic [1:0]        in_size,
   input  logic              in_signext,
   output logic [DATA_W-1:0] out_data,
   output logic              out_misalign
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] keep_mask;
   logic [DATA_W-1:0] msb_mask;
   logic [DATA_W-1:0] result;
   logic              legal;
   logic              aligned;
   logic              fill;

   always_comb begin
      shifted   = in_data >> {in_offset, 3'b000};
      keep_mask = '1;
      legal     = 1'b1;
      aligned   = 1'b1;
      case (size_e'(in_size))
         SZ_BYTE: keep_mask = DATA_W'(8'hFF);
         SZ_HALF: begin
            keep_mask = DATA_W'(16'hFFFF);
            aligned   = ~in_offset[0];
         end
         SZ_WORD: begin
            keep_mask = DATA_W'(32'hFFFF_FFFF);
            aligned   = (in_offset[1:0] == 2'b00);
         end
         SZ_DWORD: begin
            keep_mask = '1;
            legal     = (DATA_W == 64);
            aligned   = (in_offset == '0);
         end
         default: keep_mask = '1;
      endcase
      // The top kept bit is the field MSB; a full-width field has nothing to fill.
      msb_mask     = keep_mask & ~(keep_mask >> 1);
      fill         = in_signext & (|(shifted & msb_mask));
      result       = (shifted & keep_mask) | ({DATA_W{fill}} & ~keep_mask);
      out_misalign = ~(legal & aligned);
      out_data     = out_misalign ? '0 : result;
   end

endmodule

// File: rtl/ext_pipe.sv
// Extract/extend stage behind a 2-entry skid buffer, plus a saturating count
// of misaligned requests. Only already-extended results are buffered.
module ext_pipe
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 8,
   localparam int OFF_W = $clog2(DATA_W/8)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [OFF_W-1:0]  in_offset,
   input  logic [1:0]        in_size,
   input  logic              in_signext,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_misalign,
   output logic [CNT_W-1:0]  misalign_cnt,
   output buf_state_e        state_dbg
);

   // Handshake: a transfer happens on a rising edge where valid and ready are
   // both 1. in_ready is a flop (state != FULL), so it never depends on out_ready
   // in the same cycle; the skid entry absorbs the request caught by that lag.

   logic [DATA_W-1:0] fld_data;
   logic              fld_mis;

   ext_field #(.DATA_W(DATA_W)) u_field (
      .in_data      (in_data),
      .in_offset    (in_offset),
      .in_size      (in_size),
      .in_signext   (in_signext),
      .out_data     (fld_data),
      .out_misalign (fld_mis)
   );

   buf_state_e        state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_mis_q, out_mis_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              skid_mis_q, skid_mis_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              in_xfer;
   logic              out_xfer;

   always_comb begin
      in_xfer     = in_valid & in_ready_q;
      out_xfer    = out_valid_q & out_ready;
      state_d     = state_q;
      out_data_d  = out_data_q;
      out_mis_d   = out_mis_q;
      skid_data_d = skid_data_q;
      skid_mis_d  = skid_mis_q;
      cnt_d       = cnt_q;

      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               out_data_d = fld_data;
               out_mis_d  = fld_mis;
               state_d    = ONE;
            end
         end
         ONE: begin
            case ({in_xfer, out_xfer})
               2'b10: begin
                  skid_data_d = fld_data;
                  skid_mis_d  = fld_mis;
                  state_d     = FULL;
               end
               2'b01: state_d = EMPTY;
               2'b11: begin
                  out_data_d = fld_data;
                  out_mis_d  = fld_mis;
               end
               default: state_d = ONE;
            endcase
         end
         FULL: begin
            if (out_xfer) begin
               out_data_d = skid_data_q;
               out_mis_d  = skid_mis_q;
               state_d    = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != FULL);

      if (in_xfer && fld_mis && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_mis_q   <= 1'b0;
         skid_data_q <= '0;
         skid_mis_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_mis_q   <= out_mis_d;
         skid_data_q <= skid_data_d;
         skid_mis_q  <= skid_mis_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_misalign = out_mis_q;
   assign misalign_cnt = cnt_q;
   assign state_dbg    = state_q;

endmodule
